// File: rtl/neighbor_sink_scan_if.sv
// Shared-memory port plus en/start/done sequencing for the neighbor/sink scanner.
// master = scanner side, slave = controller/memory side.
interface neighbor_sink_scan_if #(
  parameter int WORD_WIDTH = 16
) ();
  logic                  en;
  logic                  start;
  logic [WORD_WIDTH-1:0] MY_CLUSTER_ID;
  logic [WORD_WIDTH-1:0] data_in;
  logic [WORD_WIDTH-1:0] address;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] data_out;
  logic                  forAggregation;
  logic [WORD_WIDTH-1:0] match_count;
  logic                  busy;
  logic                  done;

  modport master (
    input  en, start, MY_CLUSTER_ID, data_in,
    output address, wr_en, data_out, forAggregation, match_count, busy, done
  );

  modport slave (
    output en, start, MY_CLUSTER_ID, data_in,
    input  address, wr_en, data_out, forAggregation, match_count, busy, done
  );
endinterface

// File: rtl/neighbor_sink_scan.sv
// Walks neighborID/clusterID against knownSinks and writes forAggregation + match count.
// One memory access per cycle (read data valid the cycle after the address); no backpressure, en/start only sampled when idle/armed/done.
module neighbor_sink_scan #(
  parameter int                    WORD_WIDTH    = 16,
  parameter logic [WORD_WIDTH-1:0] ADDR_KSC      = 16'h688,
  parameter logic [WORD_WIDTH-1:0] ADDR_NBC      = 16'h68A,
  parameter logic [WORD_WIDTH-1:0] ADDR_NID      = 16'h48,
  parameter logic [WORD_WIDTH-1:0] ADDR_CID      = 16'hC8,
  parameter logic [WORD_WIDTH-1:0] ADDR_SINK     = 16'h8,
  parameter logic [WORD_WIDTH-1:0] ADDR_FLAG     = 16'h2,
  parameter logic [WORD_WIDTH-1:0] ADDR_MCNT     = 16'h4,
  parameter int                    ADDR_STRIDE   = 2,
  parameter int                    MAX_NEIGHBORS = 64,
  parameter int                    MAX_SINKS     = 32,
  parameter bit                    COUNT_ALL     = 1'b0
) (
  input  logic                 clock,
  input  logic                 rst,
  neighbor_sink_scan_if.master bus
);

  localparam logic [WORD_WIDTH-1:0] STRIDE = WORD_WIDTH'(ADDR_STRIDE);
  localparam logic [WORD_WIDTH-1:0] MAX_NB = WORD_WIDTH'(MAX_NEIGHBORS);
  localparam logic [WORD_WIDTH-1:0] MAX_SK = WORD_WIDTH'(MAX_SINKS);

  typedef enum logic [3:0] {
    S_IDLE, S_ARMED, S_RD_KSC, S_RD_NBC, S_RD_NID, S_RD_CID,
    S_CMP, S_NEXT_NB, S_WR_FLAG, S_WR_CNT, S_DONE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [WORD_WIDTH-1:0] r_address, w_address_nxt;
  logic                  r_wr_en, w_wr_en_nxt;
  logic [WORD_WIDTH-1:0] r_data_out, w_data_out_nxt;
  logic                  r_flag, w_flag_nxt;
  logic [WORD_WIDTH-1:0] r_mcnt, w_mcnt_nxt;
  logic [WORD_WIDTH-1:0] r_i, w_i_nxt;
  logic [WORD_WIDTH-1:0] r_j, w_j_nxt;
  logic [WORD_WIDTH-1:0] r_ksc, w_ksc_nxt;
  logic [WORD_WIDTH-1:0] r_nbc, w_nbc_nxt;
  logic [WORD_WIDTH-1:0] r_nid, w_nid_nxt;
  logic                  w_clear;
  logic                  w_go_flag;
  logic [WORD_WIDTH-1:0] w_cnt_clamp;
  logic [WORD_WIDTH-1:0] w_i_inc;
  logic [WORD_WIDTH-1:0] w_j_inc;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_address  <= ADDR_KSC;
      r_wr_en    <= 1'b0;
      r_data_out <= '0;
      r_flag     <= 1'b0;
      r_mcnt     <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_ksc      <= '0;
      r_nbc      <= '0;
      r_nid      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_address  <= w_address_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_data_out <= w_data_out_nxt;
      r_flag     <= w_flag_nxt;
      r_mcnt     <= w_mcnt_nxt;
      r_i        <= w_i_nxt;
      r_j        <= w_j_nxt;
      r_ksc      <= w_ksc_nxt;
      r_nbc      <= w_nbc_nxt;
      r_nid      <= w_nid_nxt;
    end
  end

  assign w_i_inc = r_i + 1'b1;
  assign w_j_inc = r_j + 1'b1;

  always_comb begin
    w_state_nxt    = r_state;
    w_address_nxt  = r_address;
    w_wr_en_nxt    = r_wr_en;
    w_data_out_nxt = r_data_out;
    w_flag_nxt     = r_flag;
    w_mcnt_nxt     = r_mcnt;
    w_i_nxt        = r_i;
    w_j_nxt        = r_j;
    w_ksc_nxt      = r_ksc;
    w_nbc_nxt      = r_nbc;
    w_nid_nxt      = r_nid;
    w_clear        = 1'b0;
    w_go_flag      = 1'b0;
    w_cnt_clamp    = '0;

    case (r_state)
      S_IDLE, S_DONE: w_clear = bus.en;
      S_ARMED: begin
        if (bus.start) begin
          w_address_nxt = ADDR_KSC;
          w_state_nxt   = S_RD_KSC;
        end
      end
      S_RD_KSC: begin
        w_ksc_nxt     = (bus.data_in > MAX_SK) ? MAX_SK : bus.data_in;
        w_address_nxt = ADDR_NBC;
        w_state_nxt   = S_RD_NBC;
      end
      S_RD_NBC: begin
        w_cnt_clamp = (bus.data_in > MAX_NB) ? MAX_NB : bus.data_in;
        w_nbc_nxt   = w_cnt_clamp;
        if (w_cnt_clamp == '0 || r_ksc == '0) begin
          w_go_flag = 1'b1;
        end else begin
          w_address_nxt = ADDR_NID;
          w_state_nxt   = S_RD_NID;
        end
      end
      S_RD_NID: begin
        w_nid_nxt     = bus.data_in;
        w_address_nxt = ADDR_CID + STRIDE * r_i;
        w_state_nxt   = S_RD_CID;
      end
      S_RD_CID: begin
        if (bus.data_in == bus.MY_CLUSTER_ID) begin
          w_state_nxt = S_NEXT_NB;
        end else begin
          w_address_nxt = ADDR_SINK;
          w_j_nxt       = '0;
          w_state_nxt   = S_CMP;
        end
      end
      S_CMP: begin
        // A neighbor counts once: the first sink hit ends its loop.
        if (bus.data_in == r_nid) begin
          w_mcnt_nxt  = (r_mcnt == '1) ? r_mcnt : r_mcnt + 1'b1;
          w_state_nxt = S_NEXT_NB;
        end else begin
          w_j_nxt = w_j_inc;
          if (w_j_inc == r_ksc) begin
            w_state_nxt = S_NEXT_NB;
          end else begin
            w_address_nxt = ADDR_SINK + STRIDE * w_j_inc;
          end
        end
      end
      S_NEXT_NB: begin
        w_i_nxt = w_i_inc;
        if ((!COUNT_ALL && r_mcnt != '0) || w_i_inc == r_nbc) begin
          w_go_flag = 1'b1;
        end else begin
          w_address_nxt = ADDR_NID + STRIDE * w_i_inc;
          w_state_nxt   = S_RD_NID;
        end
      end
      S_WR_FLAG: begin
        w_address_nxt  = ADDR_MCNT;
        w_data_out_nxt = r_mcnt;
        w_state_nxt    = S_WR_CNT;
      end
      S_WR_CNT: begin
        w_wr_en_nxt = 1'b0;
        w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are registered on state entry so wr_en spans exactly WR_FLAG and WR_CNT.
    if (w_go_flag) begin
      w_flag_nxt     = (r_mcnt != '0);
      w_address_nxt  = ADDR_FLAG;
      w_data_out_nxt = {{(WORD_WIDTH-1){1'b0}}, (r_mcnt != '0)};
      w_wr_en_nxt    = 1'b1;
      w_state_nxt    = S_WR_FLAG;
    end

    if (w_clear) begin
      w_address_nxt  = ADDR_KSC;
      w_wr_en_nxt    = 1'b0;
      w_data_out_nxt = '0;
      w_flag_nxt     = 1'b0;
      w_mcnt_nxt     = '0;
      w_i_nxt        = '0;
      w_j_nxt        = '0;
      w_ksc_nxt      = '0;
      w_nbc_nxt      = '0;
      w_nid_nxt      = '0;
      w_state_nxt    = S_ARMED;
    end
  end

  assign bus.address        = r_address;
  assign bus.wr_en          = r_wr_en;
  assign bus.data_out       = r_data_out;
  assign bus.forAggregation = r_flag;
  assign bus.match_count    = r_mcnt;
  assign bus.done           = (r_state == S_DONE);
  assign bus.busy           = !(r_state == S_IDLE || r_state == S_ARMED || r_state == S_DONE);

endmodule

// File: tb/tb_neighbor_sink_scan.sv
// Runs a stop-at-first and a count-all scanner side by side on one shared table memory;
// expected memory writes go into per-instance queues and are checked by a separate monitor.
module tb_neighbor_sink_scan;

  localparam int KSC  = 'h688;
  localparam int NBC  = 'h68A;
  localparam int NID  = 'h48;
  localparam int CID  = 'hC8;
  localparam int SINK = 'h8;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic        en    = 1'b0;
  logic        start = 1'b0;
  logic [15:0] mycid = '0;
  logic [15:0] mem [0:2047];

  int total = 0;
  int bad   = 0;

  logic [31:0] expq0 [$];
  logic [31:0] expq1 [$];

  neighbor_sink_scan_if #(.WORD_WIDTH(16)) bus0 ();
  neighbor_sink_scan_if #(.WORD_WIDTH(16)) bus1 ();

  neighbor_sink_scan #(.COUNT_ALL(1'b0)) u_dut0 (.clock(clock), .rst(rst), .bus(bus0));
  neighbor_sink_scan #(.COUNT_ALL(1'b1)) u_dut1 (.clock(clock), .rst(rst), .bus(bus1));

  always #5 clock = ~clock;

  assign bus0.en = en;
  assign bus1.en = en;
  assign bus0.start = start;
  assign bus1.start = start;
  assign bus0.MY_CLUSTER_ID = mycid;
  assign bus1.MY_CLUSTER_ID = mycid;
  assign bus0.data_in = mem[bus0.address[10:0]];
  assign bus1.data_in = mem[bus1.address[10:0]];

  logic [15:0] m_addr [2];
  logic [15:0] m_dout [2];
  logic [15:0] m_mcnt [2];
  logic        m_wr   [2];
  logic        m_flag [2];
  logic        m_busy [2];
  logic        m_done [2];
  assign m_addr[0] = bus0.address;        assign m_addr[1] = bus1.address;
  assign m_dout[0] = bus0.data_out;       assign m_dout[1] = bus1.data_out;
  assign m_mcnt[0] = bus0.match_count;    assign m_mcnt[1] = bus1.match_count;
  assign m_wr[0]   = bus0.wr_en;          assign m_wr[1]   = bus1.wr_en;
  assign m_flag[0] = bus0.forAggregation; assign m_flag[1] = bus1.forAggregation;
  assign m_busy[0] = bus0.busy;           assign m_busy[1] = bus1.busy;
  assign m_done[0] = bus0.done;           assign m_done[1] = bus1.done;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-scan observations, cleared when busy rises.
  int   st_nid  [2] = '{0, 0};
  int   st_maxs [2] = '{-1, -1};
  int   st_wr   [2] = '{0, 0};
  logic prev_busy [2] = '{1'b0, 1'b0};

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      logic [31:0] e;
      int          have;
      if (m_busy[k] && !prev_busy[k]) begin
        st_nid[k]  <= 0;
        st_maxs[k] <= -1;
        st_wr[k]   <= 0;
      end else if (m_busy[k]) begin
        if (m_addr[k] >= 16'(NID) && m_addr[k] < 16'(CID)) st_nid[k] <= st_nid[k] + 1;
        if (m_addr[k] >= 16'(SINK) && m_addr[k] < 16'(NID) &&
            int'((m_addr[k] - 16'(SINK)) >> 1) > st_maxs[k])
          st_maxs[k] <= int'((m_addr[k] - 16'(SINK)) >> 1);
        if (m_wr[k]) st_wr[k] <= st_wr[k] + 1;
      end
      prev_busy[k] <= m_busy[k];
      if (m_wr[k]) begin
        have = (k == 0) ? expq0.size() : expq1.size();
        if (have == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write dut%0d: addr=%0h data=%0h, no write expected", k, m_addr[k], m_dout[k]);
        end else begin
          e = (k == 0) ? expq0.pop_front() : expq1.pop_front();
          chk($sformatf("write_addr dut%0d", k), m_addr[k], e[31:16]);
          chk($sformatf("write_data dut%0d", k), m_dout[k], e[15:0]);
        end
      end
    end
  end

  // Reference: plain loop over the tables as the scan rules describe them.
  function automatic void model(input bit ca, input int my, output int flag, output int cnt,
                                output int cyc, output int vis, output int maxs);
    int ksc, nbc, k;
    bit hit;
    ksc = int'(mem[KSC]); if (ksc > 32) ksc = 32;
    nbc = int'(mem[NBC]); if (nbc > 64) nbc = 64;
    cnt = 0; cyc = 5; vis = 0; maxs = -1;
    if (ksc != 0 && nbc != 0) begin
      for (int n = 0; n < nbc; n++) begin
        vis++;
        cyc += 3;
        if (int'(mem[CID + 2*n]) != my) begin
          k = ksc; hit = 0;
          for (int s = 0; s < ksc; s++)
            if (!hit && mem[SINK + 2*s] == mem[NID + 2*n]) begin hit = 1; k = s + 1; end
          cyc += k;
          if (k - 1 > maxs) maxs = k - 1;
          if (hit) cnt++;
        end
        if (!ca && cnt != 0) break;
      end
    end
    flag = (cnt != 0) ? 1 : 0;
  endfunction

  task automatic check_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_address dut%0d", k), m_addr[k], 'h688);
      chk($sformatf("rst_wr_en dut%0d", k), m_wr[k], 0);
      chk($sformatf("rst_data_out dut%0d", k), m_dout[k], 0);
      chk($sformatf("rst_flag dut%0d", k), m_flag[k], 0);
      chk($sformatf("rst_mcnt dut%0d", k), m_mcnt[k], 0);
      chk($sformatf("rst_done dut%0d", k), m_done[k], 0);
      chk($sformatf("rst_busy dut%0d", k), m_busy[k], 0);
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 2048; a++) mem[a] = '0;
  endtask

  task automatic run_scan(input int my, input bit noise);
    int f [2], c [2], cy [2], v [2], ms [2], d [2];
    model(1'b0, my, f[0], c[0], cy[0], v[0], ms[0]);
    model(1'b1, my, f[1], c[1], cy[1], v[1], ms[1]);
    expq0.push_back({16'h2, 16'(f[0])}); expq0.push_back({16'h4, 16'(c[0])});
    expq1.push_back({16'h2, 16'(f[1])}); expq1.push_back({16'h4, 16'(c[1])});
    mycid = 16'(my);
    en = 1'b1;
    @(negedge clock);
    en = 1'b0;
    for (int k = 0; k < 2; k++) chk($sformatf("armed_mcnt dut%0d", k), m_mcnt[k], 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    d = '{0, 0};
    for (int n = 1; n <= 3000; n++) begin
      if (d[0] == 0 && bus0.done) d[0] = n;
      if (d[1] == 0 && bus1.done) d[1] = n;
      if (d[0] != 0 && d[1] != 0) break;
      if (noise && bus0.busy && bus1.busy) begin
        en = 1'($urandom);
        start = 1'($urandom);
      end else begin
        en = 1'b0;
        start = 1'b0;
      end
      @(negedge clock);
    end
    en = 1'b0;
    start = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("scan_cycles dut%0d", k), d[k], cy[k]);
      chk($sformatf("flag dut%0d", k), m_flag[k], f[k]);
      chk($sformatf("match_count dut%0d", k), m_mcnt[k], c[k]);
      chk($sformatf("done_held dut%0d", k), m_done[k], 1);
      chk($sformatf("busy_done dut%0d", k), m_busy[k], 0);
      chk($sformatf("neighbors_read dut%0d", k), st_nid[k], v[k]);
      chk($sformatf("max_sink_idx dut%0d", k), st_maxs[k], ms[k]);
      chk($sformatf("wr_cycles dut%0d", k), st_wr[k], 2);
    end
    chk("pending_writes dut0", expq0.size(), 0);
    chk("pending_writes dut1", expq1.size(), 0);
    expq0.delete();
    expq1.delete();
  endtask

  task automatic base_tables();
    clear_mem();
    mem[KSC] = 2; mem[SINK] = 5; mem[SINK + 2] = 9;
    mem[NBC] = 3;
    mem[NID] = 3; mem[NID + 2] = 9; mem[NID + 4] = 5;
    mem[CID] = 1; mem[CID + 2] = 2; mem[CID + 4] = 2;
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    repeat (3) @(negedge clock);
    check_reset();
    rst = 1'b0;
    @(negedge clock);

    base_tables();
    run_scan(1, 1'b0);

    base_tables();
    mem[CID] = 1; mem[CID + 2] = 1; mem[CID + 4] = 1;
    run_scan(1, 1'b0);

    base_tables();
    mem[NBC] = 0;
    run_scan(1, 1'b0);

    base_tables();
    mem[KSC] = 0;
    run_scan(1, 1'b0);

    clear_mem();
    mem[KSC] = 100;
    for (int s = 0; s < 32; s++) mem[SINK + 2*s] = 16'(100 + s);
    mem[NBC] = 1; mem[NID] = 7; mem[CID] = 3;
    run_scan(0, 1'b0);

    // Abort a scan while it is walking the sink table.
    clear_mem();
    mem[KSC] = 32; mem[NBC] = 4;
    for (int s = 0; s < 32; s++) mem[SINK + 2*s] = 16'd200;
    for (int n = 0; n < 4; n++) begin mem[NID + 2*n] = 1; mem[CID + 2*n] = 2; end
    mycid = 16'd1;
    en = 1'b1; @(negedge clock); en = 1'b0;
    start = 1'b1; @(negedge clock); start = 1'b0;
    waited = 0;
    while (!(bus0.address >= 16'(SINK + 4) && bus0.address < 16'(NID)) && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    chk("reach_cmp_before_abort", int'(waited < 200), 1);
    rst = 1'b1;
    @(negedge clock);
    check_reset();
    rst = 1'b0;
    repeat (3) @(negedge clock);
    base_tables();
    run_scan(1, 1'b0);

    for (int t = 0; t < 16; t++) begin
      clear_mem();
      mem[KSC] = 16'($urandom_range(0, 40));
      mem[NBC] = 16'($urandom_range(0, 70));
      for (int s = 0; s < 32; s++) mem[SINK + 2*s] = 16'($urandom_range(0, 15));
      for (int n = 0; n < 64; n++) begin
        mem[NID + 2*n] = 16'($urandom_range(0, 15));
        mem[CID + 2*n] = 16'($urandom_range(0, 3));
      end
      run_scan(int'($urandom_range(0, 3)), t[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, limit 3000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
